// File: rtl/branch_predictor_pkg.sv
// Constants shared between the branch predictor and the fetch stage.
// Counter encodings, default geometry and the reset PC.
package bp_pkg;

   localparam logic [1:0]  CTR_SNT  = 2'b00;
   localparam logic [1:0]  CTR_WNT  = 2'b01;
   localparam logic [1:0]  CTR_WT   = 2'b10;
   localparam logic [1:0]  CTR_ST   = 2'b11;

   localparam int          BP_IDX_W = 6;
   localparam int          BP_TAG_W = 32 - BP_IDX_W - 2;

   localparam logic [31:0] RESET_PC = 32'hBFC00000;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-value logic for a 2-bit saturating direction counter.
// The counter moves toward the resolved direction and clamps at 00 and 11.
module sat_counter2
   import bp_pkg::*;
(
   input  logic [1:0] cur,
   input  logic       inc,
   output logic [1:0] nxt
);

   always_comb begin
      nxt = cur;
      if (inc) begin
         if (cur != CTR_ST) nxt = cur + 2'd1;
      end else begin
         if (cur != CTR_SNT) nxt = cur - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit direction counter per entry.
// Lookup is combinational off registered state; training happens on the update port at the clock edge.
module branch_predictor #(
   parameter int         IDX_W     = bp_pkg::BP_IDX_W,
   parameter int         TAG_W     = 32 - IDX_W - 2,
   parameter logic [1:0] CTR_INIT  = bp_pkg::CTR_WNT,
   parameter logic [1:0] CTR_ALLOC = bp_pkg::CTR_WT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_pc,
   output logic        predicted_taken,
   output logic [31:0] predicted_addr,
   output logic        btb_hit,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target
);

   import bp_pkg::*;

   localparam int ENTRIES = 1 << IDX_W;

   logic [ENTRIES-1:0] valid_q;
   logic [1:0]         ctr_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];

   logic [IDX_W-1:0]   f_idx;
   logic [TAG_W-1:0]   f_tag;
   logic [IDX_W-1:0]   u_idx;
   logic [TAG_W-1:0]   u_tag;
   logic               u_hit;
   logic               upd_we;
   logic               alloc;
   logic [1:0]         ctr_sat;
   logic [1:0]         ctr_d;
   logic               unused_pc_lsbs;

   assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

   // Fetch-side lookup: read-before-write against any same-cycle update.
   assign f_idx           = fetch_pc[IDX_W+1:2];
   assign f_tag           = fetch_pc[31:IDX_W+2];
   assign btb_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign predicted_taken = btb_hit && ctr_q[f_idx][1];
   assign predicted_addr  = btb_hit ? target_q[f_idx] : 32'h0;

   assign u_idx  = upd_pc[IDX_W+1:2];
   assign u_tag  = upd_pc[31:IDX_W+2];
   assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign upd_we = upd_en && !rst;
   assign alloc  = !u_hit && upd_taken;

   sat_counter2 u_sat (
      .cur (ctr_q[u_idx]),
      .inc (upd_taken),
      .nxt (ctr_sat)
   );

   assign ctr_d = u_hit ? ctr_sat : CTR_ALLOC;

   // Control state: valid bits and counters, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
      end else if (upd_en && (u_hit || alloc)) begin
         valid_q[u_idx] <= 1'b1;
         ctr_q[u_idx]   <= ctr_d;
      end
   end

   // Data state: tags and targets are never reset, only qualified by valid.
   always_ff @(posedge clk) begin
      if (upd_we && upd_taken) begin
         target_q[u_idx] <= upd_target;
         if (alloc) tag_q[u_idx] <= u_tag;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against a table-level reference model of the BTB.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fetch_pc;
   logic        predicted_taken;
   logic [31:0] predicted_addr;
   logic        btb_hit;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;

   int tests = 0;
   int fails = 0;

   // reference model: one record per index, counter kept as a plain integer 0..3
   bit          m_valid [64];
   int          m_ctr   [64];
   logic [31:0] m_tag   [64];
   logic [31:0] m_tgt   [64];

   logic        o_hit, o_tk;
   logic [31:0] o_addr;

   localparam logic [31:0] PA = 32'hBFC00010;
   localparam logic [31:0] PB = 32'hBFC00110;
   localparam logic [31:0] PC = 32'hBFC00210;
   localparam logic [31:0] TA = 32'hBFC00100;
   localparam logic [31:0] TB = 32'hBFC00500;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_pc        (fetch_pc),
      .predicted_taken (predicted_taken),
      .predicted_addr  (predicted_addr),
      .btb_hit         (btb_hit),
      .upd_en          (upd_en),
      .upd_pc          (upd_pc),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", t, o, e);
      end
   endtask

   function automatic int m_index(input logic [31:0] pc);
      return int'((pc >> 2) % 64);
   endfunction

   function automatic bit m_lookup_hit(input logic [31:0] pc);
      int i = m_index(pc);
      return m_valid[i] && (m_tag[i] == (pc >> 8));
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
   endtask

   task automatic m_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
      int i = m_index(pc);
      if (m_lookup_hit(pc)) begin
         if (tk) begin
            m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = tgt;
         end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
         end
      end else if (tk) begin
         m_valid[i] = 1'b1;
         m_tag[i]   = pc >> 8;
         m_tgt[i]   = tgt;
         m_ctr[i]   = 2;
      end
   endtask

   // One cycle: drive on negedge, check the lookup before the edge, then advance the model.
   task automatic step(input bit r, input bit ue, input logic [31:0] up, input bit ut,
                       input logic [31:0] utg, input logic [31:0] fpc);
      bit  eh;
      @(negedge clk);
      rst        = r;
      upd_en     = ue;
      upd_pc     = up;
      upd_taken  = ut;
      upd_target = utg;
      fetch_pc   = fpc;
      #1;
      o_hit  = btb_hit;
      o_tk   = predicted_taken;
      o_addr = predicted_addr;
      eh = m_lookup_hit(fpc);
      chk("model_hit",   {31'd0, o_hit}, {31'd0, eh});
      chk("model_taken", {31'd0, o_tk},  {31'd0, (eh && m_ctr[m_index(fpc)] >= 2)});
      chk("model_addr",  o_addr, eh ? m_tgt[m_index(fpc)] : 32'h0);
      @(posedge clk);
      if (r) m_reset();
      else if (ue) m_update(up, ut, utg);
   endtask

   task automatic look(input logic [31:0] fpc);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, fpc);
   endtask

   initial begin
      logic [31:0] up, fp;
      bit          r, ue, ut;

      rst = 1'b1; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
      fetch_pc = 32'hBFC00000;
      m_reset();
      repeat (2) @(posedge clk);

      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'hBFC00000);
      look(32'hBFC00000);
      chk("rst_hit",   {31'd0, o_hit}, 32'd0);
      chk("rst_taken", {31'd0, o_tk},  32'd0);
      chk("rst_addr",  o_addr,         32'h0);

      // allocation, observed the cycle after the write
      step(1'b0, 1'b1, PA, 1'b1, TA, PA);
      chk("same_cycle_hit", {31'd0, o_hit}, 32'd0);
      look(PA);
      chk("alloc_hit",   {31'd0, o_hit}, 32'd1);
      chk("alloc_taken", {31'd0, o_tk},  32'd1);
      chk("alloc_addr",  o_addr,         TA);

      // two not-taken updates: 10 -> 01 -> 00
      step(1'b0, 1'b1, PA, 1'b0, 32'h0, PA);
      look(PA);
      chk("nt1_taken", {31'd0, o_tk},  32'd0);
      chk("nt1_hit",   {31'd0, o_hit}, 32'd1);
      step(1'b0, 1'b1, PA, 1'b0, 32'h0, PA);
      look(PA);
      chk("nt2_hit",   {31'd0, o_hit}, 32'd1);
      chk("nt2_taken", {31'd0, o_tk},  32'd0);

      // 00 -> 01 -> 10 -> 11, a 4th taken holds 11, then one NT still predicts taken
      step(1'b0, 1'b1, PA, 1'b1, TA, PA);
      look(PA);
      chk("t1_taken", {31'd0, o_tk}, 32'd0);
      step(1'b0, 1'b1, PA, 1'b1, TA, PA);
      look(PA);
      chk("t2_taken", {31'd0, o_tk}, 32'd1);
      step(1'b0, 1'b1, PA, 1'b1, TA, PA);
      step(1'b0, 1'b1, PA, 1'b1, TA, PA);
      step(1'b0, 1'b1, PA, 1'b0, 32'h0, PA);
      look(PA);
      chk("sat_hi_taken", {31'd0, o_tk}, 32'd1);
      step(1'b0, 1'b1, PA, 1'b0, 32'h0, PA);
      look(PA);
      chk("sat_hi_nt2_taken", {31'd0, o_tk}, 32'd0);

      // alias replacement at index 4
      step(1'b0, 1'b1, PB, 1'b1, TB, PB);
      look(PA);
      chk("alias_old_hit", {31'd0, o_hit}, 32'd0);
      look(PB);
      chk("alias_new_hit",   {31'd0, o_hit}, 32'd1);
      chk("alias_new_taken", {31'd0, o_tk},  32'd1);
      chk("alias_new_addr",  o_addr,         TB);
      step(1'b0, 1'b1, PC, 1'b0, 32'h0, PC);
      look(PB);
      chk("nt_miss_keep_hit",  {31'd0, o_hit}, 32'd1);
      chk("nt_miss_keep_addr", o_addr,         TB);
      look(PC);
      chk("nt_miss_no_alloc", {31'd0, o_hit}, 32'd0);

      // reset wins over a concurrent update
      step(1'b1, 1'b1, PA, 1'b1, TA, PB);
      look(PA);
      chk("rst_upd_a_hit", {31'd0, o_hit}, 32'd0);
      look(PB);
      chk("rst_upd_b_hit", {31'd0, o_hit}, 32'd0);

      // randomized traffic over a few aliasing tags and a handful of indices
      for (int n = 0; n < 600; n++) begin
         r  = ($urandom_range(0, 99) < 2);
         ue = ($urandom_range(0, 99) < 70);
         ut = ($urandom_range(0, 99) < 60);
         up = 32'hBFC00000 | (32'($urandom_range(0, 3)) << 8)
              | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         fp = ($urandom_range(0, 3) == 0) ? up
              : (32'hBFC00000 | (32'($urandom_range(0, 3)) << 8)
                 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)));
         step(r, ue, up, ut, $urandom, fp);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
